// File: rtl/lif_host_driver_if.sv
// lif_host_driver_if: request/result handshake and tile-pin bus for lif_host_driver.
//   req_*    : one request (input vector, weight vector, load-weights flag, run length)
//   tx_*     : byte bus and mode lines toward the neuron tile
//   spike_in : tile spike output, same clock domain
//   res_*    : result handshake (spike count, saturation flag)
// Modports: slave = the driver itself, master = the host controller / bench.
interface lif_host_driver_if #(
  parameter int unsigned SYNAPSES   = 32,
  parameter int unsigned COUNT_BITS = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [SYNAPSES-1:0]   req_inputs;
  logic [SYNAPSES-1:0]   req_weights;
  logic                  req_load_weights;
  logic [COUNT_BITS-1:0] req_run_cycles;
  logic [7:0]            tx_data;
  logic                  tx_sel_weights;
  logic                  tx_run;
  logic                  spike_in;
  logic                  res_valid;
  logic                  res_ready;
  logic [COUNT_BITS-1:0] res_spikes;
  logic                  res_saturated;

  modport slave (
    input  req_valid, req_inputs, req_weights, req_load_weights, req_run_cycles,
    input  spike_in, res_ready,
    output req_ready, tx_data, tx_sel_weights, tx_run,
    output res_valid, res_spikes, res_saturated
  );

  modport master (
    output req_valid, req_inputs, req_weights, req_load_weights, req_run_cycles,
    output spike_in, res_ready,
    input  req_ready, tx_data, tx_sel_weights, tx_run,
    input  res_valid, res_spikes, res_saturated
  );
endinterface

// File: rtl/lif_host_driver.sv
// lif_host_driver: host-side transmitter for the neuron tile byte-serial load port.
// Accepts one request, shifts the optional weight vector then the input vector out
// MSB byte first with tx_run=0, runs the neuron for run_cycles cycles while counting
// spikes, then presents the count on the result handshake.
// Ports:
//   clk   : single clock
//   reset : asynchronous, active-high
//   bus   : lif_host_driver_if.slave (request, tile bus, spike input, result)
// All outputs come straight from flops; no input reaches an output combinationally.
module lif_host_driver #(
  parameter int unsigned SYNAPSES   = 32,
  parameter int unsigned COUNT_BITS = 16
) (
  input logic              clk,
  input logic              reset,
  lif_host_driver_if.slave bus
);
  localparam int unsigned BYTES = SYNAPSES / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, RUN, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [SYNAPSES-1:0]   wsh_q, wsh_d;
  logic [SYNAPSES-1:0]   ish_q, ish_d;
  logic [IDX_W-1:0]      byte_q, byte_d;
  logic [COUNT_BITS-1:0] run_len_q, run_len_d;
  logic [COUNT_BITS-1:0] run_cnt_q, run_cnt_d;
  logic [COUNT_BITS-1:0] spikes_q, spikes_d;
  logic                  sat_q, sat_d;
  logic                  was_run_q, was_run_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_sel_q, tx_sel_d;
  logic                  tx_run_q, tx_run_d;
  logic                  req_ready_q, req_ready_d;
  logic                  res_valid_q, res_valid_d;

  always_comb begin
    state_d   = state_q;
    wsh_d     = wsh_q;
    ish_d     = ish_q;
    byte_d    = byte_q;
    run_len_d = run_len_q;
    run_cnt_d = run_cnt_q;
    spikes_d  = spikes_q;
    sat_d     = sat_q;
    // The tile's spike for RUN cycle k appears one cycle later, so a sample is
    // counted when the previous cycle was RUN (RUN cycles 2..N plus DRAIN).
    was_run_d = (state_q == RUN);

    if (was_run_q && bus.spike_in) begin
      if (spikes_q == '1) sat_d = 1'b1;
      else                spikes_d = spikes_q + COUNT_BITS'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wsh_d     = bus.req_weights;
          ish_d     = bus.req_inputs;
          run_len_d = bus.req_run_cycles;
          spikes_d  = '0;
          sat_d     = 1'b0;
          byte_d    = '0;
          state_d   = bus.req_load_weights ? LOAD_W : LOAD_I;
        end
      end
      LOAD_W: begin
        wsh_d = wsh_q << 8;
        if (byte_q == IDX_W'(BYTES - 1)) begin
          byte_d  = '0;
          state_d = LOAD_I;
        end else begin
          byte_d = byte_q + IDX_W'(1);
        end
      end
      LOAD_I: begin
        ish_d = ish_q << 8;
        if (byte_q == IDX_W'(BYTES - 1)) begin
          byte_d    = '0;
          run_cnt_d = '0;
          state_d   = (run_len_q == '0) ? DONE : RUN;
        end else begin
          byte_d = byte_q + IDX_W'(1);
        end
      end
      RUN: begin
        if (run_cnt_q == run_len_q - COUNT_BITS'(1)) state_d = DRAIN;
        else run_cnt_d = run_cnt_q + COUNT_BITS'(1);
      end
      DRAIN:   state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so that each byte appears
  // in the same cycle its LOAD state is entered.
  always_comb begin
    tx_run_d    = !((state_d == LOAD_W) || (state_d == LOAD_I));
    tx_sel_d    = (state_d == LOAD_W);
    req_ready_d = (state_d == IDLE);
    res_valid_d = (state_d == DONE);
    tx_data_d   = '0;
    if (state_d == LOAD_W)      tx_data_d = wsh_d[SYNAPSES-1 -: 8];
    else if (state_d == LOAD_I) tx_data_d = ish_d[SYNAPSES-1 -: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wsh_q       <= '0;
      ish_q       <= '0;
      byte_q      <= '0;
      run_len_q   <= '0;
      run_cnt_q   <= '0;
      spikes_q    <= '0;
      sat_q       <= 1'b0;
      was_run_q   <= 1'b0;
      tx_data_q   <= '0;
      tx_sel_q    <= 1'b0;
      tx_run_q    <= 1'b1;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wsh_q       <= wsh_d;
      ish_q       <= ish_d;
      byte_q      <= byte_d;
      run_len_q   <= run_len_d;
      run_cnt_q   <= run_cnt_d;
      spikes_q    <= spikes_d;
      sat_q       <= sat_d;
      was_run_q   <= was_run_d;
      tx_data_q   <= tx_data_d;
      tx_sel_q    <= tx_sel_d;
      tx_run_q    <= tx_run_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.tx_data        = tx_data_q;
  assign bus.tx_sel_weights = tx_sel_q;
  assign bus.tx_run         = tx_run_q;
  assign bus.req_ready      = req_ready_q;
  assign bus.res_valid      = res_valid_q;
  assign bus.res_spikes     = spikes_q;
  assign bus.res_saturated  = sat_q;
endmodule

// File: tb/tb_lif_host_driver.sv
module tb_lif_host_driver;
  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_errors;

  lif_host_driver_if #(.SYNAPSES(32), .COUNT_BITS(16)) ifa ();
  lif_host_driver_if #(.SYNAPSES(8),  .COUNT_BITS(4))  ifb ();

  lif_host_driver #(.SYNAPSES(32), .COUNT_BITS(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  lif_host_driver #(.SYNAPSES(8), .COUNT_BITS(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request to DUT A; returns in cycle t0+1 with req_* scrambled.
  task automatic send_a(input logic [31:0] inputs, input logic [31:0] weights,
                        input logic lw, input logic [15:0] rc);
    check_eq("a_req_ready_pre", ifa.req_ready, 1);
    ifa.req_valid        = 1'b1;
    ifa.req_inputs       = inputs;
    ifa.req_weights      = weights;
    ifa.req_load_weights = lw;
    ifa.req_run_cycles   = rc;
    tick();
    ifa.req_valid        = 1'b0;
    ifa.req_inputs       = 32'hDEADBEEF;
    ifa.req_weights      = 32'hDEADBEEF;
    ifa.req_load_weights = ~lw;
    ifa.req_run_cycles   = 16'h0007;
  endtask

  task automatic expect_bytes_a(input string tag, input logic [31:0] v, input logic sel);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), ifa.tx_data, v[31-8*i -: 8]);
      check_eq($sformatf("%s_sel%0d", tag, i), ifa.tx_sel_weights, sel);
      check_eq($sformatf("%s_run%0d", tag, i), ifa.tx_run, 0);
      tick();
    end
  endtask

  task automatic finish_a(input string tag, input logic [15:0] spikes, input logic sat);
    check_eq({tag, "_res_valid"}, ifa.res_valid, 1);
    check_eq({tag, "_res_spikes"}, ifa.res_spikes, spikes);
    check_eq({tag, "_res_sat"}, ifa.res_saturated, sat);
    check_eq({tag, "_done_tx_run"}, ifa.tx_run, 1);
    check_eq({tag, "_done_tx_data"}, ifa.tx_data, 0);
    check_eq({tag, "_done_req_ready"}, ifa.req_ready, 0);
    ifa.res_ready = 1'b1;
    tick();
    ifa.res_ready = 1'b0;
    check_eq({tag, "_idle_req_ready"}, ifa.req_ready, 1);
    check_eq({tag, "_idle_res_valid"}, ifa.res_valid, 0);
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_inputs = '0; ifa.req_weights = '0;
    ifa.req_load_weights = 1'b0; ifa.req_run_cycles = '0;
    ifa.spike_in = 1'b0; ifa.res_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_inputs = '0; ifb.req_weights = '0;
    ifb.req_load_weights = 1'b0; ifb.req_run_cycles = '0;
    ifb.spike_in = 1'b0; ifb.res_ready = 1'b0;

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    check_eq("rst_tx_run", ifa.tx_run, 1);
    check_eq("rst_tx_data", ifa.tx_data, 0);
    check_eq("rst_tx_sel", ifa.tx_sel_weights, 0);
    check_eq("rst_req_ready", ifa.req_ready, 1);
    check_eq("rst_res_valid", ifa.res_valid, 0);
    check_eq("rst_res_spikes", ifa.res_spikes, 0);
    check_eq("rst_res_sat", ifa.res_saturated, 0);
    check_eq("rst_b_tx_run", ifb.tx_run, 1);
    check_eq("rst_b_req_ready", ifb.req_ready, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    tick();

    // Inputs only, no run.
    send_a(32'hA1B2C3D4, 32'h0, 1'b0, 16'd0);
    expect_bytes_a("in", 32'hA1B2C3D4, 1'b0);
    finish_a("in", 16'd0, 1'b0);

    // Weights then inputs.
    send_a(32'h00000001, 32'h0F1E2D3C, 1'b1, 16'd0);
    expect_bytes_a("wt", 32'h0F1E2D3C, 1'b1);
    expect_bytes_a("wi", 32'h00000001, 1'b0);
    finish_a("wt", 16'd0, 1'b0);

    // Run 10 with spike held high (also high during load, which must not count).
    ifa.spike_in = 1'b1;
    send_a(32'h12345678, 32'h0, 1'b0, 16'd10);
    expect_bytes_a("r10", 32'h12345678, 1'b0);
    repeat (10) tick();
    check_eq("r10_drain_valid", ifa.res_valid, 0);
    check_eq("r10_drain_run", ifa.tx_run, 1);
    tick();
    ifa.spike_in = 1'b0;
    finish_a("r10", 16'd10, 1'b0);

    // Pulses in first RUN cycle (not counted) and in DRAIN (counted).
    send_a(32'h87654321, 32'h0, 1'b0, 16'd10);
    expect_bytes_a("pl", 32'h87654321, 1'b0);
    ifa.spike_in = 1'b1;
    tick();
    ifa.spike_in = 1'b0;
    repeat (9) tick();
    check_eq("pl_drain_valid", ifa.res_valid, 0);
    ifa.spike_in = 1'b1;
    tick();
    ifa.spike_in = 1'b0;
    finish_a("pl", 16'd1, 1'b0);

    // Backpressure: DONE held 5 cycles; spikes and new requests ignored.
    ifa.spike_in = 1'b1;
    send_a(32'hCAFEF00D, 32'h0, 1'b0, 16'd3);
    expect_bytes_a("bp", 32'hCAFEF00D, 1'b0);
    repeat (4) tick();
    ifa.req_valid = 1'b1;
    ifa.req_inputs = 32'h11111111;
    ifa.req_run_cycles = 16'd2;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("bp_valid%0d", i), ifa.res_valid, 1);
      check_eq($sformatf("bp_spikes%0d", i), ifa.res_spikes, 3);
      check_eq($sformatf("bp_req_ready%0d", i), ifa.req_ready, 0);
      check_eq($sformatf("bp_tx_run%0d", i), ifa.tx_run, 1);
      tick();
    end
    ifa.req_valid = 1'b0;
    ifa.spike_in = 1'b0;
    finish_a("bp", 16'd3, 1'b0);

    // Back-to-back: res_ready in first DONE cycle, accept in the following IDLE.
    send_a(32'h11223344, 32'h0, 1'b0, 16'd0);
    expect_bytes_a("bb1", 32'h11223344, 1'b0);
    check_eq("bb1_valid", ifa.res_valid, 1);
    ifa.res_ready = 1'b1;
    ifa.req_valid = 1'b1;
    ifa.req_inputs = 32'h55667788;
    ifa.req_load_weights = 1'b0;
    ifa.req_run_cycles = 16'd0;
    tick();
    ifa.res_ready = 1'b0;
    check_eq("bb_idle_ready", ifa.req_ready, 1);
    check_eq("bb_idle_valid", ifa.res_valid, 0);
    check_eq("bb_idle_run", ifa.tx_run, 1);
    tick();
    ifa.req_valid = 1'b0;
    expect_bytes_a("bb2", 32'h55667788, 1'b0);
    finish_a("bb2", 16'd0, 1'b0);

    // Narrow counter DUT: 8 synapses, 4-bit counter.
    ifb.spike_in = 1'b1;
    ifb.req_valid = 1'b1; ifb.req_inputs = 8'h5A; ifb.req_weights = 8'h00;
    ifb.req_load_weights = 1'b0; ifb.req_run_cycles = 4'd12;
    tick();
    ifb.req_valid = 1'b0; ifb.req_inputs = 8'hFF;
    check_eq("b12_data", ifb.tx_data, 8'h5A);
    check_eq("b12_sel", ifb.tx_sel_weights, 0);
    check_eq("b12_run", ifb.tx_run, 0);
    repeat (13) tick();
    check_eq("b12_drain_valid", ifb.res_valid, 0);
    tick();
    check_eq("b12_valid", ifb.res_valid, 1);
    check_eq("b12_spikes", ifb.res_spikes, 12);
    check_eq("b12_sat", ifb.res_saturated, 0);
    ifb.res_ready = 1'b1;
    tick();
    ifb.res_ready = 1'b0;

    ifb.req_valid = 1'b1; ifb.req_inputs = 8'h5A; ifb.req_weights = 8'hC3;
    ifb.req_load_weights = 1'b1; ifb.req_run_cycles = 4'd15;
    tick();
    ifb.req_valid = 1'b0;
    check_eq("b15_wdata", ifb.tx_data, 8'hC3);
    check_eq("b15_wsel", ifb.tx_sel_weights, 1);
    tick();
    check_eq("b15_idata", ifb.tx_data, 8'h5A);
    check_eq("b15_isel", ifb.tx_sel_weights, 0);
    check_eq("b15_irun", ifb.tx_run, 0);
    repeat (16) tick();
    check_eq("b15_drain_valid", ifb.res_valid, 0);
    tick();
    check_eq("b15_valid", ifb.res_valid, 1);
    check_eq("b15_spikes", ifb.res_spikes, 15);
    check_eq("b15_sat", ifb.res_saturated, 0);
    ifb.spike_in = 1'b0;
    ifb.res_ready = 1'b1;
    tick();
    ifb.res_ready = 1'b0;

    // Abort with reset during LOAD_I.
    send_a(32'hA1B2C3D4, 32'h0, 1'b0, 16'd5);
    tick();
    check_eq("ab_load_run", ifa.tx_run, 0);
    check_eq("ab_load_data", ifa.tx_data, 8'hB2);
    #2 reset = 1'b1;
    #1;
    check_eq("ab_tx_run", ifa.tx_run, 1);
    check_eq("ab_tx_data", ifa.tx_data, 0);
    check_eq("ab_req_ready", ifa.req_ready, 1);
    check_eq("ab_res_valid", ifa.res_valid, 0);
    tick();
    #2 reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (ifa.res_valid !== 1'b0) seen = 1'b1;
    end
    check_eq("ab_no_res_valid", seen, 0);
    check_eq("ab_idle_ready", ifa.req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
